// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared state type and Wishbone cycle-type codes for the main-RAM arbiter
package wb_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage

// File: rtl/wb_arb_rr_pick.sv
// rtl/wb_arb_rr_pick.sv - combinational round-robin picker, searches from pointer+1 with wrap
module wb_arb_rr_pick #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_winner,
  output logic [IW-1:0] o_idx
);

  logic [N-1:0] w_mask;
  logic [N-1:0] w_src;
  logic         w_found;

  // Prefer requesters above the pointer; fall back to the lowest requester (the wrap-around)
  always_comb begin
    w_mask = '0;
    for (int j = 0; j < N; j++) begin
      w_mask[j] = (j > int'(i_ptr));
    end
    w_src    = (|(i_req & w_mask)) ? (i_req & w_mask) : i_req;
    o_winner = '0;
    o_idx    = '0;
    w_found  = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!w_found && w_src[j]) begin
        o_winner[j] = 1'b1;
        o_idx       = IW'(j);
        w_found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_mem_arbiter.sv
// rtl/wb_mem_arbiter.sv - round-robin Wishbone arbiter for main RAM; WB_MEM_ARBITER_TIMEOUT_EN adds a stall timeout
module wb_mem_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 3,
  parameter int AW          = 32,
  parameter int DW          = 32
`ifdef WB_MEM_ARBITER_TIMEOUT_EN
  ,parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_ni,
  input  logic [NUM_MASTERS*AW-1:0]     m_adr_i,
  input  logic [NUM_MASTERS*DW-1:0]     m_dat_i,
  input  logic [NUM_MASTERS*DW/8-1:0]   m_sel_i,
  input  logic [NUM_MASTERS-1:0]        m_we_i,
  input  logic [NUM_MASTERS-1:0]        m_cyc_i,
  input  logic [NUM_MASTERS-1:0]        m_stb_i,
  input  logic [NUM_MASTERS*3-1:0]      m_cti_i,
  input  logic [NUM_MASTERS*2-1:0]      m_bte_i,
  output logic [DW-1:0]                 m_dat_o,
  output logic [NUM_MASTERS-1:0]        m_ack_o,
  output logic [NUM_MASTERS-1:0]        m_err_o,
  output logic [NUM_MASTERS-1:0]        m_rty_o,
  output logic [AW-1:0]                 s_adr_o,
  output logic [DW-1:0]                 s_dat_o,
  output logic [DW/8-1:0]               s_sel_o,
  output logic                          s_we_o,
  output logic                          s_cyc_o,
  output logic                          s_stb_o,
  output logic [2:0]                    s_cti_o,
  output logic [1:0]                    s_bte_o,
  input  logic [DW-1:0]                 s_dat_i,
  input  logic                          s_ack_i,
  input  logic                          s_err_i,
  input  logic                          s_rty_i,
  output logic [NUM_MASTERS-1:0]        grant_o
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int SW = DW / 8;

  arb_state_t             r_state, w_state_nxt;
  logic [NUM_MASTERS-1:0] r_grant, w_grant_nxt;
  logic [IW-1:0]          r_ptr, w_ptr_nxt;
  logic [NUM_MASTERS-1:0] w_winner;
  logic [IW-1:0]          w_win_idx;
  logic                   w_gnt_cyc;
  logic                   w_stb_raw;
  logic                   w_timeout;

  wb_arb_rr_pick #(.N(NUM_MASTERS), .IW(IW)) u_pick (
    .i_req    (m_cyc_i),
    .i_ptr    (r_ptr),
    .o_winner (w_winner),
    .o_idx    (w_win_idx)
  );

  assign w_gnt_cyc = |(m_cyc_i & r_grant);

  // State, grant and pointer registers; pointer starts at the last master so master 0 wins first
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state <= ARB_IDLE;
      r_grant <= '0;
      r_ptr   <= IW'(NUM_MASTERS - 1);
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // Grant is taken in IDLE and held until the owner drops cyc, regardless of burst type
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ARB_IDLE: begin
        if (|m_cyc_i) begin
          w_grant_nxt = w_winner;
          w_ptr_nxt   = w_win_idx;
          w_state_nxt = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (!w_gnt_cyc) begin
          w_grant_nxt = '0;
          w_state_nxt = ARB_IDLE;
        end
      end
      default: begin
        w_grant_nxt = '0;
        w_state_nxt = ARB_IDLE;
      end
    endcase
  end

  // Request mux; a zero grant vector (IDLE or reset) drives every slave field to 0
  always_comb begin
    s_adr_o   = '0;
    s_dat_o   = '0;
    s_sel_o   = '0;
    s_we_o    = 1'b0;
    s_cyc_o   = 1'b0;
    w_stb_raw = 1'b0;
    s_cti_o   = '0;
    s_bte_o   = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (r_grant[k]) begin
        s_adr_o   = m_adr_i[k*AW +: AW];
        s_dat_o   = m_dat_i[k*DW +: DW];
        s_sel_o   = m_sel_i[k*SW +: SW];
        s_we_o    = m_we_i[k];
        s_cyc_o   = m_cyc_i[k];
        w_stb_raw = m_stb_i[k];
        s_cti_o   = m_cti_i[k*3 +: 3];
        s_bte_o   = m_bte_i[k*2 +: 2];
      end
    end
  end

`ifdef WB_MEM_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_to_cnt;
  logic          w_resp;
  logic          w_stall;

  assign w_resp    = s_ack_i | s_err_i | s_rty_i;
  assign w_stall   = (r_state == ARB_GRANT) && w_stb_raw && !w_resp;
  // Fires on the TIMEOUT_CYCLES-th consecutive unanswered strobe
  assign w_timeout = w_stall && (r_to_cnt == CW'(TIMEOUT_CYCLES - 1));

  // Stall counter: restarts on any response, on a timeout, and whenever no grant is held
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_to_cnt <= '0;
    end else if ((r_state != ARB_GRANT) || w_resp || w_timeout) begin
      r_to_cnt <= '0;
    end else if (w_stall) begin
      r_to_cnt <= r_to_cnt + CW'(1);
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  assign s_stb_o = w_stb_raw & ~w_timeout;
  assign m_dat_o = s_dat_i;
  assign m_ack_o = r_grant & {NUM_MASTERS{s_ack_i}};
  assign m_err_o = r_grant & {NUM_MASTERS{s_err_i | w_timeout}};
  assign m_rty_o = r_grant & {NUM_MASTERS{s_rty_i}};
  assign grant_o = r_grant;

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// tb/tb_wb_mem_arbiter.sv - self-checking bench for wb_mem_arbiter with a transaction-level rotation model
module tb_wb_mem_arbiter;
  import wb_arb_pkg::*;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef WB_MEM_ARBITER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic [N*AW-1:0]   m_adr;
  logic [N*DW-1:0]   m_dat;
  logic [N*DW/8-1:0] m_sel;
  logic [N-1:0]      m_we, m_cyc, m_stb;
  logic [N*3-1:0]    m_cti;
  logic [N*2-1:0]    m_bte;
  logic [DW-1:0]     rd_dat;
  logic [N-1:0]      m_ack, m_err, m_rty;
  logic [AW-1:0]     s_adr;
  logic [DW-1:0]     s_wdat;
  logic [DW/8-1:0]   s_sel;
  logic              s_we, s_cyc, s_stb;
  logic [2:0]        s_cti;
  logic [1:0]        s_bte;
  logic [DW-1:0]     s_rdat;
  logic              s_ack, s_err, s_rty;
  logic [N-1:0]      grant;

  int n_tests;
  int n_fail;

`ifdef WB_MEM_ARBITER_TIMEOUT_EN
  wb_mem_arbiter #(.NUM_MASTERS(N), .AW(AW), .DW(DW), .TIMEOUT_CYCLES(16)) dut (
`else
  wb_mem_arbiter #(.NUM_MASTERS(N), .AW(AW), .DW(DW)) dut (
`endif
    .wb_clk_i (clk),    .wb_rst_ni (rst_n),
    .m_adr_i  (m_adr),  .m_dat_i   (m_dat),  .m_sel_i (m_sel),
    .m_we_i   (m_we),   .m_cyc_i   (m_cyc),  .m_stb_i (m_stb),
    .m_cti_i  (m_cti),  .m_bte_i   (m_bte),
    .m_dat_o  (rd_dat), .m_ack_o   (m_ack),  .m_err_o (m_err), .m_rty_o (m_rty),
    .s_adr_o  (s_adr),  .s_dat_o   (s_wdat), .s_sel_o (s_sel), .s_we_o  (s_we),
    .s_cyc_o  (s_cyc),  .s_stb_o   (s_stb),  .s_cti_o (s_cti), .s_bte_o (s_bte),
    .s_dat_i  (s_rdat), .s_ack_i   (s_ack),  .s_err_i (s_err), .s_rty_i (s_rty),
    .grant_o  (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs;
    m_adr = '0; m_dat = '0; m_sel = '0; m_we = '0; m_cyc = '0; m_stb = '0;
    m_cti = '0; m_bte = '0; s_rdat = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic set_master(input int k, input logic cyc, input logic stb, input logic we,
                            input logic [31:0] adr, input logic [31:0] dat, input logic [2:0] cti);
    m_cyc[k] = cyc; m_stb[k] = stb; m_we[k] = we;
    m_adr[k*AW +: AW] = adr; m_dat[k*DW +: DW] = dat;
    m_sel[k*4 +: 4] = 4'hf; m_cti[k*3 +: 3] = cti; m_bte[k*2 +: 2] = 2'b00;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst_n = 1'b0;
    m_cyc = '1; m_stb = '1; m_adr = {32'h3000, 32'h2000, 32'h1000}; s_ack = 1'b1;
    next_cycle();
    @(negedge clk);
    n_tests++; if (grant !== 3'b000) begin n_fail++; $display("FAIL reset_grant: got %b want 000", grant); end
    n_tests++; if (s_cyc !== 1'b0 || s_stb !== 1'b0) begin n_fail++; $display("FAIL reset_cyc_stb: got %b%b want 00", s_cyc, s_stb); end
    n_tests++; if (s_adr !== 32'h0) begin n_fail++; $display("FAIL reset_adr: got %h want 0", s_adr); end
    n_tests++; if (m_ack !== 3'b000) begin n_fail++; $display("FAIL reset_ack: got %b want 000", m_ack); end
    next_cycle();
    idle_inputs();
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++; if (grant !== 3'b000) begin n_fail++; $display("FAIL reset_idle_grant: got %b want 000", grant); end
    next_cycle();
  endtask

  task automatic test_single_read;
    logic [31:0] rd;
    do_reset();
    rd = $urandom;
    set_master(1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0, CTI_CLASSIC);
    @(negedge clk);
    n_tests++; if (s_cyc !== 1'b0 || grant !== 3'b000) begin n_fail++; $display("FAIL t1_early: cyc %b grant %b want 0 000", s_cyc, grant); end
    next_cycle();
    @(negedge clk);
    n_tests++; if (s_adr !== 32'h100) begin n_fail++; $display("FAIL t1_adr: got %h want 100", s_adr); end
    n_tests++; if (s_cyc !== 1'b1 || s_stb !== 1'b1) begin n_fail++; $display("FAIL t1_cyc_stb: got %b%b want 11", s_cyc, s_stb); end
    n_tests++; if (grant !== 3'b010) begin n_fail++; $display("FAIL t1_grant: got %b want 010", grant); end
    n_tests++; if (m_ack !== 3'b000) begin n_fail++; $display("FAIL t1_ack_early: got %b want 000", m_ack); end
    next_cycle();
    s_ack = 1'b1; s_rdat = rd;
    @(negedge clk);
    n_tests++; if (m_ack !== 3'b010) begin n_fail++; $display("FAIL t1_ack: got %b want 010", m_ack); end
    n_tests++; if (rd_dat !== rd) begin n_fail++; $display("FAIL t1_rdata: got %h want %h", rd_dat, rd); end
    next_cycle();
    s_ack = 1'b0;
    set_master(1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0, CTI_CLASSIC);
    @(negedge clk);
    n_tests++; if (m_ack !== 3'b000 || s_cyc !== 1'b0) begin n_fail++; $display("FAIL t1_release: ack %b cyc %b want 000 0", m_ack, s_cyc); end
    next_cycle();
    @(negedge clk);
    n_tests++; if (grant !== 3'b000) begin n_fail++; $display("FAIL t1_grant_clear: got %b want 000", grant); end
    n_tests++; if (s_adr !== 32'h0) begin n_fail++; $display("FAIL t1_idle_adr: got %h want 0", s_adr); end
    next_cycle();
  endtask

  task automatic test_rotation;
    logic [N-1:0] pend, last_g;
    int order[$];
    do_reset();
    last_g = '0;
    for (int r = 0; r < 2; r++) begin
      pend = '1;
      for (int c = 0; c < 40 && pend != 0; c++) begin
        m_cyc = pend; m_stb = pend; s_ack = 1'b0;
        #1;
        s_ack = s_stb;
        @(negedge clk);
        n_tests++; if ($countones(grant) > 1) begin n_fail++; $display("FAIL rot_onehot: got %b want at most one bit", grant); end
        if (grant != 0 && grant != last_g) order.push_back($clog2(grant));
        last_g = grant;
        pend = pend & ~m_ack;
        next_cycle();
      end
      m_cyc = '0; m_stb = '0; s_ack = 1'b0;
      n_tests++; if (pend != 0) begin n_fail++; $display("FAIL rot_timeout: pending %b want 000", pend); end
      next_cycle();
      next_cycle();
    end
    n_tests++; if (order.size() != 6) begin n_fail++; $display("FAIL rot_count: got %0d grants want 6", order.size()); end
    for (int i = 0; i < order.size() && i < 6; i++) begin
      n_tests++; if (order[i] != i % 3) begin n_fail++; $display("FAIL rot_order[%0d]: got %0d want %0d", i, order[i], i % 3); end
    end
  endtask

  task automatic test_burst;
    int beats, fall_c, m2_start;
    logic m2_req, m2_done;
    do_reset();
    beats = 0; fall_c = -1; m2_start = -1; m2_req = 1'b0; m2_done = 1'b0;
    for (int c = 0; c < 60 && !m2_done; c++) begin
      if (beats < 8) begin
        set_master(0, 1'b1, 1'b1, 1'b0, 32'h200 + 4 * beats, 32'h0, (beats == 7) ? CTI_EOB : CTI_INCR);
      end else begin
        set_master(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
        if (fall_c < 0) fall_c = c;
      end
      if (m2_req) set_master(2, 1'b1, 1'b1, 1'b0, 32'h280, 32'h0, CTI_CLASSIC);
      s_ack = 1'b0;
      #1;
      s_ack = s_stb;
      @(negedge clk);
      if (m_cyc[0] && c >= 1) begin
        n_tests++; if (grant !== 3'b001) begin n_fail++; $display("FAIL burst_hold c%0d: got %b want 001", c, grant); end
        n_tests++; if (s_adr !== 32'h200 + 4 * beats) begin n_fail++; $display("FAIL burst_adr c%0d: got %h want %h", c, s_adr, 32'h200 + 4 * beats); end
      end
      if (s_cyc && grant[2] && m2_start < 0) m2_start = c;
      if (m_ack[0]) beats++;
      if (beats >= 3) m2_req = 1'b1;
      if (m_ack[2]) m2_done = 1'b1;
      next_cycle();
    end
    idle_inputs();
    n_tests++; if (!m2_done) begin n_fail++; $display("FAIL burst_m2_done: got 0 want 1"); end
    n_tests++; if (m2_start != fall_c + 2) begin n_fail++; $display("FAIL burst_m2_latency: got cycle %0d want %0d", m2_start, fall_c + 2); end
    next_cycle();
    next_cycle();
  endtask

  task automatic test_reset_mid;
    do_reset();
    set_master(1, 1'b1, 1'b1, 1'b0, 32'h500, 32'h0, CTI_INCR);
    for (int c = 0; c < 3; c++) begin
      s_ack = 1'b0;
      #1;
      s_ack = s_stb;
      next_cycle();
    end
    s_ack = 1'b0;
    @(negedge clk);
    n_tests++; if (grant !== 3'b010) begin n_fail++; $display("FAIL rmid_pre_grant: got %b want 010", grant); end
    next_cycle();
    rst_n = 1'b0;
    #1;
    n_tests++; if (s_cyc !== 1'b0 || grant !== 3'b000) begin n_fail++; $display("FAIL rmid_async: cyc %b grant %b want 0 000", s_cyc, grant); end
    next_cycle();
    set_master(2, 1'b1, 1'b1, 1'b0, 32'h600, 32'h0, CTI_CLASSIC);
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++; if (grant !== 3'b000) begin n_fail++; $display("FAIL rmid_idle: got %b want 000", grant); end
    next_cycle();
    @(negedge clk);
    n_tests++; if (grant !== 3'b010) begin n_fail++; $display("FAIL rmid_first: got %b want 010", grant); end
    next_cycle();
    idle_inputs();
    next_cycle();
    next_cycle();
  endtask

  task automatic test_error;
    do_reset();
    set_master(2, 1'b1, 1'b1, 1'b1, 32'h4, $urandom, CTI_CLASSIC);
    next_cycle();
    s_err = 1'b1;
    @(negedge clk);
    n_tests++; if (m_err !== 3'b100) begin n_fail++; $display("FAIL err_route: got %b want 100", m_err); end
    n_tests++; if (m_ack !== 3'b000) begin n_fail++; $display("FAIL err_no_ack: got %b want 000", m_ack); end
    n_tests++; if (s_adr !== 32'h4 || s_we !== 1'b1) begin n_fail++; $display("FAIL err_req: adr %h we %b want 4 1", s_adr, s_we); end
    next_cycle();
    s_err = 1'b0;
    m_stb[2] = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_tests++; if (grant !== 3'b100 || m_err !== 3'b000) begin n_fail++; $display("FAIL err_hold: grant %b err %b want 100 000", grant, m_err); end
      next_cycle();
    end
    idle_inputs();
    next_cycle();
    next_cycle();
  endtask

  task automatic test_timeout;
    logic exp_to;
    do_reset();
    set_master(0, 1'b1, 1'b1, 1'b0, 32'h300, 32'h0, CTI_CLASSIC);
    next_cycle();
    for (int s = 1; s <= 40; s++) begin
      exp_to = TO_EN && (s % 16 == 0);
      @(negedge clk);
      n_tests++; if (m_err !== (exp_to ? 3'b001 : 3'b000)) begin n_fail++; $display("FAIL to_err s%0d: got %b want %b", s, m_err, exp_to ? 3'b001 : 3'b000); end
      n_tests++; if (s_stb !== !exp_to) begin n_fail++; $display("FAIL to_stb s%0d: got %b want %b", s, s_stb, !exp_to); end
      next_cycle();
    end
    idle_inputs();
    next_cycle();
    next_cycle();
  endtask

  task automatic test_random;
    int holder, last_win, r;
    int rem[N];
    logic act[N];
    logic cool[N];
    logic [N-1:0] exp_g, exp_ack;
    logic [31:0] exp_adr;
    do_reset();
    holder = -1; last_win = N - 1;
    for (int k = 0; k < N; k++) begin rem[k] = 0; act[k] = 1'b0; cool[k] = 1'b0; end
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!act[k] && !cool[k] && $urandom_range(3) == 0) begin
          act[k] = 1'b1;
          rem[k] = $urandom_range(3, 1);
          set_master(k, 1'b1, 1'b1, 1'($urandom_range(1)), $urandom & 32'hffff_fffc, $urandom, CTI_CLASSIC);
        end
        cool[k] = 1'b0;
        m_cyc[k] = act[k];
        m_stb[k] = act[k];
      end
      s_ack = 1'b0; s_err = 1'b0; s_rdat = $urandom;
      #1;
      if (s_stb) begin
        r = $urandom_range(7);
        s_ack = (r < 4);
        s_err = (r == 4);
      end
      @(negedge clk);
      exp_g   = (holder < 0) ? 3'b000 : 3'(1 << holder);
      exp_adr = (holder < 0) ? 32'h0 : m_adr[holder*AW +: AW];
      exp_ack = (holder >= 0 && s_ack) ? 3'(1 << holder) : 3'b000;
      n_tests++; if (grant !== exp_g) begin n_fail++; $display("FAIL rnd_grant c%0d: got %b want %b", c, grant, exp_g); end
      n_tests++; if (s_cyc !== (holder >= 0 && m_cyc[holder])) begin n_fail++; $display("FAIL rnd_cyc c%0d: got %b want %b", c, s_cyc, holder >= 0 && m_cyc[holder]); end
      n_tests++; if (s_adr !== exp_adr) begin n_fail++; $display("FAIL rnd_adr c%0d: got %h want %h", c, s_adr, exp_adr); end
      n_tests++; if (m_ack !== exp_ack) begin n_fail++; $display("FAIL rnd_ack c%0d: got %b want %b", c, m_ack, exp_ack); end
      for (int k = 0; k < N; k++) begin
        if (m_ack[k] || m_err[k]) begin
          rem[k]--;
          m_adr[k*AW +: AW] = m_adr[k*AW +: AW] + 32'd4;
          if (rem[k] == 0) begin act[k] = 1'b0; cool[k] = 1'b1; end
        end
      end
      if (holder < 0) begin
        for (int i = 1; i <= N; i++) begin
          if (holder < 0 && m_cyc[(last_win + i) % N]) begin
            holder = (last_win + i) % N;
            last_win = holder;
          end
        end
      end else if (!m_cyc[holder]) begin
        holder = -1;
      end
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    idle_inputs();
    test_reset();
    test_single_read();
    test_rotation();
    test_burst();
    test_reset_mid();
    test_error();
    test_timeout();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
